// File: rtl/uart_tx_shifter.sv
// rtl/uart_tx_shifter.sv - UART transmit framer/shifter with one-entry holding register
//
// Ports:
//   clk_i      system clock, rising edge
//   reset_n_i  synchronous active-low reset
//   baud_i     one-clock baud tick, one per bit time
//   data_i     character to transmit (DATA_BITS wide)
//   wr_i       write strobe, accepted only while rdy_o=1
//   rdy_o      holding register empty
//   busy_o     frame in progress or holding register full
//   txd_o      registered serial output, idles high
module uart_tx_shifter #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 baud_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 wr_i,
    output logic                 rdy_o,
    output logic                 busy_o,
    output logic                 txd_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   par_q, par_d;
    logic                   txd_q, txd_d;
    logic                   load;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        par_d       = par_q;
        txd_d       = txd_q;
        load        = 1'b0;

        if (baud_i) begin
            case (state_q)
                S_IDLE: begin
                    if (hold_full_q) begin
                        load = 1'b1;
                    end
                end
                S_START: begin
                    state_d   = S_DATA;
                    txd_d     = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = 4'd0;
                end
                S_DATA: begin
                    // bit_cnt_q is the index of the bit whose period is ending
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d    = S_STOP;
                            txd_d      = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        txd_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                S_PARITY: begin
                    state_d    = S_STOP;
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                end
                S_STOP: begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        if (hold_full_q) begin
                            // next character queued: start bit follows immediately
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    txd_d   = 1'b1;
                end
            endcase
        end

        if (load) begin
            state_d     = S_START;
            txd_d       = 1'b0;
            shift_d     = hold_q;
            par_d       = (PARITY == 1) ? ~^hold_q : ^hold_q;
            hold_full_d = 1'b0;
        end

        // load needs a full holding register and a write needs an empty one,
        // so a write never collides with the transfer
        if (wr_i && !hold_full_q) begin
            hold_d      = data_i;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= 4'd0;
            stop_cnt_q  <= 1'b0;
            par_q       <= 1'b0;
            txd_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            par_q       <= par_d;
            txd_q       <= txd_d;
        end
    end

    assign rdy_o  = !hold_full_q;
    assign busy_o = (state_q != S_IDLE) || hold_full_q;
    assign txd_o  = txd_q;

endmodule

// File: doc/uart_tx_shifter.md
Name: uart_tx_shifter

Overview:
- Serial transmit stage that consumes the one-clock baud tick produced by the baudrate generator.
- Frames parallel bytes as start / data (LSB first) / optional parity / stop bits on txd_o.
- A one-entry holding register lets the host queue the next character while the current one shifts, so back-to-back frames leave no idle gap.
- Sits between the host/bus interface and the TXD pin.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- reset_n_i  input  1  synchronous, active-low reset.
- baud_i  input  1  one-clock baud tick from the baudrate generator; one tick per bit time.
- data_i  input  DATA_BITS  character to transmit.
- wr_i  input  1  write strobe; accepted only while rdy_o=1.
- rdy_o  output  1  holding register empty, write will be accepted.
- busy_o  output  1  frame in progress or holding register full.
- txd_o  output  1  serial output; idle level 1.

Behaviour:
- Reset: reset_n_i=0 at a rising edge forces the following on the next edge:
  - txd_o=1, rdy_o=1, busy_o=0, state=IDLE;
  - holding register and shifter contents discarded.
  - Reset mid-frame aborts immediately: txd_o returns to 1 one clock later.
- Write handshake:
  - wr_i=1 with rdy_o=1 latches data_i into the holding register; rdy_o=0 from the next cycle.
  - wr_i while rdy_o=0 is ignored; holding contents are unchanged and no error is flagged.
- Timing:
  - All state and bit transitions occur only on cycles with baud_i=1.
  - txd_o is registered and changes the clock after the baud_i tick that causes the transition.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE:
    - txd_o=1.
    - On baud_i with holding full: load shifter from holding, compute parity, go to START, drive txd_o=0.
    - Holding is freed in the same cycle, so rdy_o=1 next cycle.
  - START: on baud_i, go to DATA and output bit 0.
  - DATA:
    - Each baud_i outputs the next bit, LSB first; a bit counter counts DATA_BITS bits.
    - After the last data bit's period: go to PARITY if PARITY!=0, else STOP.
  - PARITY:
    - Outputs the parity bit. Odd mode: data plus parity has an odd number of ones. Even mode: an even number.
    - On baud_i, go to STOP.
  - STOP:
    - txd_o=1 for STOP_BITS baud periods.
    - At the tick ending the last stop bit: if holding is full, load it and go directly to START (txd_o=0, back-to-back); otherwise go to IDLE.
- Simultaneous events:
  - wr_i accepted on the same cycle as baud_i in IDLE with holding empty: the character lands in holding; the frame starts on the next baud_i, not this one.
  - wr_i on the cycle holding is being transferred to the shifter: rdy_o is still 0, so the write is ignored.
- busy_o = (state != IDLE) OR (holding full). It is registered-equivalent: it derives only from registers, with no combinational path from wr_i.
- baud_i held high continuously: one bit per clock. This is legal, and the behaviour above still applies.
- Latency: first start-bit edge occurs 1 clock after the first baud_i following the write.
- Frame length: 1 + DATA_BITS + (PARITY!=0) + STOP_BITS baud periods.

Test Plan:
- 8N1, baud_i every 4 clocks, write 0xA5 -> txd_o per baud period = 0,1,0,1,0,0,1,0,1,1; then idle at 1; busy_o falls at the tick ending the stop bit.
- PARITY=2 then PARITY=1, write 0xA5 -> parity bit 0 (even) and 1 (odd), inserted after bit 7 and before the stop bit.
- Back-to-back: write 0x55, then write 0x0F while 0x55 shifts -> second start bit immediately follows the stop bit with no idle period; a third wr_i while rdy_o=0 is ignored.
- STOP_BITS=2, DATA_BITS=7, write 0x7F -> 0, seven 1s, then 1,1; total 10 baud periods.
- Assert reset_n_i=0 during data bit 3 -> txd_o=1, rdy_o=1, busy_o=0 one clock later; a new write after release produces a clean full frame.
- wr_i and baud_i coincident in IDLE -> no start bit on that tick; start bit begins after the next tick.
